chunked_adder: RTL and testbench
================================

CHUNKED_ADDER -- requirements
Module: chunked_adder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and reset; all state SHALL change only on the rising edge of clk.
REQ-002 Parameter WIDTH SHALL default to 32 and set the operand width in bits.
REQ-003 Parameter CHUNK SHALL default to 8 and set the bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK, 1 <= CHUNK <= WIDTH.
REQ-004 Derived constant N = WIDTH/CHUNK SHALL set the number of RUN cycles.
REQ-005 The ports SHALL be:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  request a new operation
- sub  in  1  0 = add, 1 = subtract
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in, add mode only
- busy  out  1  operation in progress
- done  out  1  one-cycle result-valid pulse
- sum  out  WIDTH  result
- carry  out  1  carry-out; in subtract mode 1 = no borrow
- overflow  out  1  signed overflow
- zero  out  1  sum == 0

Function
REQ-006 The FSM SHALL have three states, IDLE, RUN and DONE, with a RUN chunk counter of ceil(log2(N+1)) bits.
REQ-007 On a clk edge in IDLE or DONE with start=1, the block SHALL:
- latch a into operand register A;
- latch b' = sub ? ~b : b into operand register B;
- set the running carry to sub ? 1 : cin (cin ignored when sub=1);
- clear the chunk counter and enter RUN.
REQ-008 Each RUN edge SHALL:
- add the low CHUNK bits of A, the low CHUNK bits of B and the running carry;
- place the CHUNK-bit result into the MSB end of a result shift register (logical right shift);
- update the running carry;
- logically shift A and B right by CHUNK;
- increment the counter.
REQ-009 On the Nth RUN edge the FSM SHALL enter DONE and register sum, carry, overflow and zero together on that same edge.
REQ-010 Latency: with start sampled high at edge t, done SHALL be 1 exactly in the cycle after edge t+N and 0 otherwise. For CHUNK=WIDTH, done is high in the cycle after edge t+1.
REQ-011 busy SHALL be 1 while in RUN and 0 in IDLE and DONE.
REQ-012 done SHALL be 1 only in DONE, for exactly one cycle per accepted start.
REQ-013 From DONE, the FSM SHALL go to IDLE if start=0, or accept a new operation per REQ-007 if start=1, giving back-to-back throughput of one result per N+1 cycles.
REQ-014 start, a, b, sub and cin SHALL be ignored while busy=1; a start during RUN SHALL be dropped, not queued.
REQ-015 sum, carry, overflow and zero SHALL change only on the edge entering DONE and SHALL hold their values otherwise, including after return to IDLE.
REQ-016 overflow SHALL be (A[WIDTH-1] == b'[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]), using the latched original MSBs.
REQ-017 carry SHALL be the final running carry after chunk N-1.
REQ-018 zero SHALL be 1 if and only if the registered sum is all zeros.
REQ-019 All arithmetic SHALL be unsigned modulo 2^WIDTH; no output other than carry SHALL depend on bits beyond WIDTH.

Reset
REQ-020 While reset=1 at an edge, the block SHALL enter IDLE and clear busy, done, sum, carry, overflow, zero, the counter and the operand/carry registers to 0.
REQ-021 reset SHALL take priority over start on the same edge.
REQ-022 Reset during RUN SHALL abort the operation: no done pulse and no output update for the aborted operation.
REQ-023 The first start SHALL be accepted on the first edge where reset=0 and start=1.

Verification
REQ-024 Add, WIDTH=32, CHUNK=8: a=0, b=0, cin=0 -> busy high for 4 cycles, done in cycle 5 after start; sum=0, carry=0, overflow=0, zero=1.
REQ-025 Add: a=FFFFFFFF, b=00000001, cin=0 -> sum=0, carry=1, zero=1, overflow=0. Add: a=7FFFFFFF, b=1 -> sum=80000000, overflow=1, carry=0.
REQ-026 Subtract: a=5, b=7, cin=1 -> sum=FFFFFFFE, carry=0, overflow=0 (cin ignored). Subtract: a=7, b=5 -> sum=2, carry=1. Subtract: a=80000000, b=1 -> sum=7FFFFFFF, overflow=1.
REQ-027 Handshake: start pulsed again at the 2nd RUN cycle is ignored and exactly one done occurs. start held high through DONE starts a second operation with no IDLE cycle, and its done arrives N+1 cycles later.
REQ-028 Reset asserted at the 3rd RUN edge -> IDLE on that edge, no done, all outputs 0. A following start works normally.
REQ-029 WIDTH=1, CHUNK=1, add, cin=0: inputs 00, 01, 10, 11 -> (sum, carry) = 00, 10, 10, 01, with done one cycle after each accepted start edge.

Source files
------------

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock over N = WIDTH/CHUNK cycles.
// Results, flags and the done pulse are registered on the edge that completes the last chunk.
`timescale 1ns/1ps
module chunked_adder #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow,
   output logic             zero
);

   localparam int unsigned N     = WIDTH / CHUNK;
   localparam int unsigned CNT_W = $clog2(N + 1);
   localparam int unsigned CS_W  = CHUNK + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic             carry_q;
   logic             a_msb;
   logic             b_msb;
   logic [CNT_W-1:0] cnt;

   logic [CHUNK:0]   chunk_sum;
   logic [WIDTH-1:0] res_next;

   // One chunk of ripple addition; the chunk result enters the result register from the MSB end.
   always_comb begin
      chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + CS_W'(carry_q);
      res_next  = (res_q >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         carry_q  <= 1'b0;
         a_msb    <= 1'b0;
         b_msb    <= 1'b0;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sum      <= '0;
         carry    <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_q     <= a;
                  b_q     <= sub ? ~b : b;
                  carry_q <= sub | cin;
                  a_msb   <= a[WIDTH-1];
                  b_msb   <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
                  res_q   <= '0;
                  cnt     <= '0;
                  busy    <= 1'b1;
                  state   <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               a_q     <= a_q >> CHUNK;
               b_q     <= b_q >> CHUNK;
               carry_q <= chunk_sum[CHUNK];
               res_q   <= res_next;
               cnt     <= cnt + CNT_W'(1);
               // Last chunk: publish the result and flags together with done.
               if (cnt == CNT_W'(N - 1)) begin
                  state    <= DONE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  sum      <= res_next;
                  carry    <= chunk_sum[CHUNK];
                  overflow <= (a_msb == b_msb) && (res_next[WIDTH-1] != a_msb);
                  zero     <= (res_next == '0);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_chunked_adder.sv
// Directed bench for chunked_adder: scoreboard of expected results, checked when done pulses.
`timescale 1ns/1ps
module tb_chunked_adder;

   localparam int unsigned W = 32;
   localparam int unsigned C = 8;
   localparam int unsigned N = W / C;

   typedef struct {
      logic [W-1:0] sum;
      logic         carry;
      logic         ovf;
      logic         zero;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
      logic         cin;
   } op_t;

   logic         clk = 1'b0;
   logic         reset, start, sub, cin;
   logic [W-1:0] a, b;
   logic         busy, done, carry, overflow, zero;
   logic [W-1:0] sum;

   logic start1, sub1, cin1, a1, b1;
   logic busy1, done1, sum1, carry1, overflow1, zero1;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   chunked_adder #(.WIDTH(W), .CHUNK(C)) dut (
      .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .carry(carry), .overflow(overflow), .zero(zero)
   );

   chunked_adder #(.WIDTH(1), .CHUNK(1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .sub(sub1), .a(a1), .b(b1), .cin(cin1),
      .busy(busy1), .done(done1), .sum(sum1), .carry(carry1), .overflow(overflow1), .zero(zero1)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Reference arithmetic on full-width integers, pushed at the start edge.
   task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic sv, input logic cv);
      logic [W:0]   t;
      logic [W-1:0] bb;
      exp_t         e;
      bb      = sv ? ~bv : bv;
      t       = {1'b0, av} + {1'b0, bb} + (W+1)'(sv ? 1'b1 : cv);
      e.sum   = t[W-1:0];
      e.carry = t[W];
      e.ovf   = (av[W-1] == bb[W-1]) && (t[W-1] != av[W-1]);
      e.zero  = (t[W-1:0] == '0);
      sbq.push_back(e);
      a = av; b = bv; sub = sv; cin = cv; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, output int n, output int nbusy);
      n = 0;
      nbusy = 0;
      while (done !== 1'b1 && n < 20) begin
         if (busy === 1'b1) nbusy++;
         n++;
         tick();
      end
      chk({tag, "_done"}, W'(done), W'(1));
      chk({tag, "_busy_at_done"}, W'(busy), W'(0));
   endtask

   task automatic check_result(input string tag);
      exp_t e;
      chk({tag, "_sb_size"}, W'(sbq.size()), W'(1));
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk({tag, "_sum"}, sum, e.sum);
         chk({tag, "_carry"}, W'(carry), W'(e.carry));
         chk({tag, "_ovf"}, W'(overflow), W'(e.ovf));
         chk({tag, "_zero"}, W'(zero), W'(e.zero));
      end
   endtask

   op_t ops[7];

   initial begin
      int          n, nb, cnt_done, cnt_busy;
      logic [W-1:0] held;
      logic [1:0]   e1;

      reset = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
      start1 = 1'b0; sub1 = 1'b0; cin1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
      tick(); tick();
      chk("rst_busy", W'(busy), W'(0));
      chk("rst_done", W'(done), W'(0));
      chk("rst_sum", sum, W'(0));
      chk("rst_carry", W'(carry), W'(0));
      chk("rst_ovf", W'(overflow), W'(0));
      chk("rst_zero", W'(zero), W'(0));
      reset = 1'b0;

      ops[0] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
      ops[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0};
      ops[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0};
      ops[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1};
      ops[4] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0};
      ops[5] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0};
      ops[6] = '{32'h1234_80FF, 32'h00FF_7F01, 1'b0, 1'b1};

      for (int i = 0; i < 7; i++) begin
         start_op(ops[i].a, ops[i].b, ops[i].sub, ops[i].cin);
         wait_done($sformatf("op%0d", i), n, nb);
         chk($sformatf("op%0d_latency", i), W'(n), W'(N));
         chk($sformatf("op%0d_busy_cycles", i), W'(nb), W'(N));
         held = sum;
         check_result($sformatf("op%0d", i));
         tick();
         chk($sformatf("op%0d_done_pulse", i), W'(done), W'(0));
         tick();
         chk($sformatf("op%0d_sum_hold", i), sum, held);
      end

      // A start during RUN must be dropped.
      start_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
      tick();
      a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("drop", n, nb);
      chk("drop_latency", W'(n), W'(N - 2));
      check_result("drop");
      cnt_done = 0; cnt_busy = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done === 1'b1) cnt_done++;
         if (busy === 1'b1) cnt_busy++;
      end
      chk("drop_extra_done", W'(cnt_done), W'(0));
      chk("drop_extra_busy", W'(cnt_busy), W'(0));

      // Back-to-back: new start accepted in the DONE cycle.
      start_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
      wait_done("b2b1", n, nb);
      check_result("b2b1");
      start_op(32'hA5A5_A5A5, 32'h5A5A_5A5B, 1'b1, 1'b0);
      chk("b2b_busy_no_idle", W'(busy), W'(1));
      wait_done("b2b2", n, nb);
      chk("b2b2_latency", W'(n + 1), W'(N + 1));
      check_result("b2b2");

      // Reset at the 3rd RUN edge aborts the operation.
      start_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
      tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      void'(sbq.pop_back());
      chk("abort_busy", W'(busy), W'(0));
      chk("abort_done", W'(done), W'(0));
      chk("abort_sum", sum, W'(0));
      chk("abort_carry", W'(carry), W'(0));
      chk("abort_ovf", W'(overflow), W'(0));
      chk("abort_zero", W'(zero), W'(0));
      cnt_done = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done === 1'b1) cnt_done++;
      end
      chk("abort_no_done", W'(cnt_done), W'(0));
      start_op(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0);
      wait_done("post_abort", n, nb);
      chk("post_abort_latency", W'(n), W'(N));
      check_result("post_abort");

      // WIDTH=1, CHUNK=1 instance: expected {sum,carry} = 00, 10, 10, 01.
      for (int i = 0; i < 4; i++) begin
         a1 = i[1]; b1 = i[0]; start1 = 1'b1;
         tick();
         start1 = 1'b0;
         chk($sformatf("w1_%0d_busy", i), W'(busy1), W'(1));
         chk($sformatf("w1_%0d_early_done", i), W'(done1), W'(0));
         tick();
         chk($sformatf("w1_%0d_done", i), W'(done1), W'(1));
         e1 = (i == 0) ? 2'b00 : (i == 3) ? 2'b01 : 2'b10;
         chk($sformatf("w1_%0d_sum_carry", i), W'({sum1, carry1}), W'(e1));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
